// File: rtl/fp_divider_seq.sv
// fp_divider_seq: sequential IEEE-754 single-precision divider using restoring mantissa division.
// Define FPDIV_INEXACT_EN to add the inexact output.
module fp_divider_seq #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic        overflow,
   output logic        underflow,
   output logic        infinity,
   output logic        NAN,
   output logic        div_by_zero
`ifdef FPDIV_INEXACT_EN
   ,
   output logic        inexact
`endif
);

   localparam int         DIV_CYCLES = 26 / BITS_PER_CYCLE;
   localparam logic [4:0] CNT_LAST   = 5'(DIV_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORMALIZE, S_PACK} state_t;
   typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_DBZ, SP_ZERO} spec_t;

   state_t            state_q;
   spec_t             spec_q, spec_d;
   logic [31:0]       a_q, b_q;
   logic              sign_q;
   logic [7:0]        ea_q, eb_q;
   logic [23:0]       mb_q, ma_d, mb_d;
   logic [25:0]       rem_q, rem_d, quo_q, quo_d;
   logic [24:0]       mant_q;
   logic [4:0]        cnt_q;
   logic signed [9:0] exp_q, exp_d, exp_r;
   logic              sticky_q;
   logic              busy_q, done_q, ovf_q, unf_q, inf_q, nan_q, dbz_q;
   logic [31:0]       quotient_q;
   logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   logic              g, r, rnd_up, ovf, unf;
   logic [23:0]       frac_sum;

   // Operand classification; denormals count as zero.
   always_comb begin
      a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
      a_zero = (a_q[30:23] == 8'h00);
      b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
      b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
      b_zero = (b_q[30:23] == 8'h00);
      ma_d   = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
      mb_d   = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
      spec_d = SP_NONE;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_d = SP_NAN;
      else if (a_inf)           spec_d = SP_INF;
      else if (b_zero)          spec_d = SP_DBZ;
      else if (b_inf || a_zero) spec_d = SP_ZERO;
   end

   // Restoring steps; the partial remainder stays below 2*mb so 26 bits suffice.
   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (rem_d >= {2'b00, mb_q}) begin
            rem_d = (rem_d - {2'b00, mb_q}) << 1;
            quo_d = {quo_d[24:0], 1'b1};
         end else begin
            rem_d = rem_d << 1;
            quo_d = {quo_d[24:0], 1'b0};
         end
      end
   end

   assign exp_d = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;

   // mant_q holds the fraction below the hidden 1, then guard and round.
   always_comb begin
      g        = mant_q[1];
      r        = mant_q[0];
      rnd_up   = g & (r | sticky_q | mant_q[2]);
      frac_sum = {1'b0, mant_q[24:2]} + {23'd0, rnd_up};
      exp_r    = exp_q + $signed({9'd0, frac_sum[23]});
      ovf      = (exp_r >= 10'sd255);
      unf      = (exp_r <= 10'sd0);
   end

`ifdef FPDIV_INEXACT_EN
   logic inx_q;
   assign inexact = inx_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         spec_q     <= SP_NONE;
         a_q        <= '0;
         b_q        <= '0;
         sign_q     <= 1'b0;
         ea_q       <= '0;
         eb_q       <= '0;
         mb_q       <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         mant_q     <= '0;
         cnt_q      <= '0;
         exp_q      <= '0;
         sticky_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quotient_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         inf_q      <= 1'b0;
         nan_q      <= 1'b0;
         dbz_q      <= 1'b0;
`ifdef FPDIV_INEXACT_EN
         inx_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               a_q     <= a;
               b_q     <= b;
               ovf_q   <= 1'b0;
               unf_q   <= 1'b0;
               inf_q   <= 1'b0;
               nan_q   <= 1'b0;
               dbz_q   <= 1'b0;
`ifdef FPDIV_INEXACT_EN
               inx_q   <= 1'b0;
`endif
               state_q <= S_UNPACK;
            end
            S_UNPACK: begin
               sign_q  <= a_q[31] ^ b_q[31];
               ea_q    <= a_q[30:23];
               eb_q    <= b_q[30:23];
               mb_q    <= mb_d;
               rem_q   <= {2'b00, ma_d};
               quo_q   <= '0;
               cnt_q   <= CNT_LAST;
               spec_q  <= spec_d;
               busy_q  <= 1'b1;
               state_q <= S_DIVIDE;
            end
            S_DIVIDE: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd0) state_q <= S_NORMALIZE;
            end
            S_NORMALIZE: begin
               sticky_q <= |rem_q;
               if (quo_q[25]) begin
                  mant_q <= quo_q[24:0];
                  exp_q  <= exp_d;
               end else begin
                  mant_q <= {quo_q[23:0], 1'b0};
                  exp_q  <= exp_d - 10'sd1;
               end
               state_q <= S_PACK;
            end
            S_PACK: begin
               case (spec_q)
                  SP_NAN:  begin quotient_q <= 32'h7FC0_0000;          nan_q <= 1'b1; end
                  SP_INF:  begin quotient_q <= {sign_q, 8'hFF, 23'd0}; inf_q <= 1'b1; end
                  SP_DBZ:  begin
                     quotient_q <= {sign_q, 8'hFF, 23'd0};
                     inf_q      <= 1'b1;
                     dbz_q      <= 1'b1;
                  end
                  SP_ZERO: quotient_q <= {sign_q, 31'd0};
                  default: begin
                     if (ovf) begin
                        quotient_q <= {sign_q, 8'hFF, 23'd0};
                        ovf_q      <= 1'b1;
                        inf_q      <= 1'b1;
                     end else if (unf) begin
                        quotient_q <= {sign_q, 31'd0};
                        unf_q      <= 1'b1;
                     end else begin
                        quotient_q <= {sign_q, exp_r[7:0], frac_sum[22:0]};
                     end
`ifdef FPDIV_INEXACT_EN
                     inx_q <= g | r | sticky_q | ovf | unf;
`endif
                  end
               endcase
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;
   assign infinity    = inf_q;
   assign NAN         = nan_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: per-cycle scoreboard against an exact-arithmetic model plus
// directed vectors with hand-computed results; a second instance covers BITS_PER_CYCLE=2.
module tb_fp_divider_seq;

   localparam int LAT = 29;
`ifdef FPDIV_INEXACT_EN
   localparam bit INX = 1'b1;
`else
   localparam bit INX = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, overflow, underflow, infinity, nan_o, dbz, inx_w;
   logic [31:0] quotient;
   logic        busy2, done2, ovf2, unf2, inf2, nan2, dbz2, inx2;
   logic [31:0] quotient2;
   logic [5:0]  flags;

   int n_tests = 0, n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   fp_divider_seq #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .quotient(quotient),
      .overflow(overflow), .underflow(underflow), .infinity(infinity),
      .NAN(nan_o), .div_by_zero(dbz)
`ifdef FPDIV_INEXACT_EN
      , .inexact(inx_w)
`endif
   );

   fp_divider_seq #(.BITS_PER_CYCLE(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy2), .done(done2), .quotient(quotient2),
      .overflow(ovf2), .underflow(unf2), .infinity(inf2),
      .NAN(nan2), .div_by_zero(dbz2)
`ifdef FPDIV_INEXACT_EN
      , .inexact(inx2)
`endif
   );

`ifndef FPDIV_INEXACT_EN
   assign inx_w = 1'b0;
   assign inx2  = 1'b0;
`endif

   assign flags = {overflow, underflow, infinity, nan_o, dbz, inx_w};

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Exact quotient by wide integer division, then round-to-nearest-even on the true remainder.
   // Result: {quotient, overflow, underflow, infinity, NAN, div_by_zero, inexact}.
   function automatic logic [37:0] model(input logic [31:0] x, input logic [31:0] y);
      logic        s, xn, xi, xz, yn, yi, yz, up, inx;
      logic [63:0] num, den, q, rem, rest, half, sig;
      int          e, sh;
      s  = x[31] ^ y[31];
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      xz = (x[30:23] == 8'h00);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      yz = (y[30:23] == 8'h00);
      if (xn || yn || (xz && yz) || (xi && yi)) return {32'h7FC0_0000, 6'b000100};
      if (xi) return {s, 8'hFF, 23'd0, 6'b001000};
      if (yz) return {s, 8'hFF, 23'd0, 6'b001010};
      if (yi || xz) return {s, 31'd0, 6'b000000};
      num = {40'd0, 1'b1, x[22:0]} << 30;
      den = {40'd0, 1'b1, y[22:0]};
      q   = num / den;
      rem = num % den;
      e   = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (q >= 64'h4000_0000) sh = 7;
      else begin
         sh = 6;
         e--;
      end
      sig  = q >> sh;
      rest = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (rest > half) || ((rest == half) && ((rem != 0) || sig[0]));
      inx  = (rest != 0) || (rem != 0);
      sig  = sig + {63'd0, up};
      if (sig == 64'h100_0000) begin
         sig = sig >> 1;
         e++;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0, 5'b10100, INX};
      if (e <= 0)   return {s, 31'd0, 5'b01000, INX};
      return {s, 8'(e), sig[22:0], 5'b00000, inx & INX};
   endfunction

   // Scoreboard timing state, updated at each rising edge from the sampled inputs.
   bit          pend = 1'b0;
   int          t_acc = -1000, done_edge = -1;
   logic [31:0] pa = '0, pb = '0, hq = '0;
   logic [5:0]  hf = '0;

   always @(posedge clk) begin
      logic        acc;
      logic [37:0] res;
      cyc++;
      if (!reset) begin
         pend      = 1'b0;
         hq        = '0;
         hf        = '0;
         done_edge = -1;
      end else begin
         acc = start && !pend;
         if (pend && cyc == t_acc + LAT) begin
            res       = model(pa, pb);
            hq        = res[37:6];
            hf        = res[5:0];
            pend      = 1'b0;
            done_edge = cyc;
         end
         if (acc) begin
            pend  = 1'b1;
            t_acc = cyc;
            pa    = a;
            pb    = b;
            hf    = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (cyc >= 1) begin
         check("busy", {31'd0, busy}, {31'd0, pend && (cyc >= t_acc + 1)});
         check("done", {31'd0, done}, {31'd0, done_edge == cyc});
         check("quotient", quotient, hq);
         check("flags", {26'd0, flags}, {26'd0, hf});
      end
   end

   int t2_lat = -1;

   task automatic wait_done(input int t0, output int lat);
      lat = -1;
      for (int i = 0; i < 45; i++) begin
         if (done2 && t2_lat < 0) t2_lat = cyc - t0;
         if (done) begin
            lat = cyc - t0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [5:0] ef);
      int t0, lat;
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      wait_done(t0, lat);
      check({nm, " latency"}, lat, LAT);
      check({nm, " q"}, quotient, eq);
      check({nm, " flags"}, {26'd0, flags}, {26'd0, ef});
   endtask

   task automatic run_model(input string nm, input logic [31:0] x, input logic [31:0] y);
      logic [37:0] res;
      res = model(x, y);
      run_op(nm, x, y, res[37:6], res[5:0]);
   endtask

   initial begin
      int t0, t1, lat, td1, npulse;
      logic [37:0] res;
      // reset held with start high: nothing may be accepted
      a = 32'h40C0_0000;
      b = 32'h4000_0000;
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset q", quotient, 32'd0);
      check("reset flags", {26'd0, flags}, 32'd0);
      start = 1'b0;
      reset = 1'b1;

      res = model(32'h40C0_0000, 32'h4000_0000);
      check("model 6/2", res[37:6], 32'h4040_0000);
      res = model(32'h3F80_0000, 32'h4040_0000);
      check("model 1/3", res[37:6], 32'h3EAA_AAAB);
      res = model(32'h7F00_0000, 32'h3E80_0000);
      check("model ovf", {26'd0, res[5:0]}, {26'd0, 5'b10100, INX});

      t2_lat = -1;
      run_op("1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, {5'b00000, INX});
      check("bpc2 latency", t2_lat, 16);
      check("bpc2 q", quotient2, 32'h3EAA_AAAB);

      run_op("6/2",     32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 6'b000000);
      run_op("-6/2",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 6'b000000);
      run_op("1/0",     32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 6'b001010);
      run_op("-1/0",    32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 6'b001010);
      run_op("0/0",     32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 6'b000100);
      run_op("ovf",     32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, {5'b10100, INX});
      run_op("unf",     32'h0080_0000, 32'h4000_0000, 32'h0000_0000, {5'b01000, INX});
      run_op("inf/0",   32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 6'b001000);
      run_op("inf/-2",  32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 6'b001000);
      run_op("2/inf",   32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 6'b000000);
      run_op("-0/5",    32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 6'b000000);
      run_op("nan/1",   32'hFFC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 6'b000100);
      run_op("inf/inf", 32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 6'b000100);

      run_model("1.5/1.25", 32'h3FC0_0000, 32'h3FA0_0000);
      run_model("mix",      32'h42F6_E979, 32'hC120_0000);
      run_model("near1",    32'h3F7F_FFFF, 32'h3F80_0001);
      run_model("denA",     32'h0040_0000, 32'h3F80_0000);
      run_model("denB",     32'h3F80_0000, 32'h0000_0001);
      run_model("maxov",    32'h7F7F_FFFF, 32'h3F00_0000);
      run_model("minnorm",  32'h0100_0000, 32'h4000_0000);
      run_model("edge",     32'h00FF_FFFF, 32'h3F80_0001);

      // start pulsed while busy must be ignored
      @(negedge clk);
      a = 32'h40C0_0000;
      b = 32'h4000_0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      repeat (4) @(negedge clk);
      a = 32'h3F80_0000;
      b = 32'h4040_0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(t0, lat);
      check("busy-start latency", lat, LAT);
      check("busy-start q", quotient, 32'h4040_0000);
      npulse = 0;
      repeat (35) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check("busy-start extra done", npulse, 0);

      // start held through the done cycle: second op one cycle after done
      @(negedge clk);
      a = 32'hC0C0_0000;
      b = 32'h4000_0000;
      start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      wait_done(t0, lat);
      check("b2b first latency", lat, LAT);
      check("b2b first q", quotient, 32'hC040_0000);
      td1 = cyc;
      a = 32'h3F80_0000;
      b = 32'h0000_0000;
      @(negedge clk);
      start = 1'b0;
      t1 = cyc;
      wait_done(t1, lat);
      check("b2b gap", cyc - td1, 30);
      check("b2b second q", quotient, 32'h7F80_0000);
      check("b2b second flags", {26'd0, flags}, {26'd0, 6'b001010});

      // reset mid-divide aborts without a done pulse
      @(negedge clk);
      a = 32'h3FC0_0000;
      b = 32'h3FA0_0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort q", quotient, 32'd0);
      check("abort flags", {26'd0, flags}, 32'd0);
      npulse = 0;
      repeat (35) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check("abort no done", npulse, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fp_divider_seq.md
Name: fp_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider; the inverse operation to the team's combinational floating-point multiplier.
- Shares the multiplier's operand format and flag set (overflow/infinity/NAN).
- Captures operands on a start/done handshake and computes the mantissa quotient by iterative restoring division.
- Sits behind the same input registers used by the multiplier datapath.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per DIVIDE cycle. Legal values are 1 or 2. Sets latency.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- a  input  32  dividend, IEEE-754 single.
- b  input  32  divisor, IEEE-754 single.
- busy  output  1  high from the cycle after start is accepted until the cycle done is high (inclusive of neither).
- done  output  1  one-cycle pulse; quotient and flags valid.
- quotient  output  32  result a/b.
- overflow  output  1  result exponent exceeded range; infinity returned.
- underflow  output  1  result below normal range; signed zero returned.
- infinity  output  1  quotient is ±inf.
- NAN  output  1  quotient is the canonical NaN 0x7FC00000.
- div_by_zero  output  1  finite nonzero / zero.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; busy, done, quotient and all flags =0. Any operation in flight is aborted with no done pulse.
- FSM states: IDLE -> UNPACK -> DIVIDE -> NORMALIZE -> PACK -> IDLE.
- IDLE: when start=1, capture a and b and go to UNPACK. busy=1 from the next cycle.
- UNPACK (1 cycle):
  - Split sign, exponent and mantissa; restore the hidden 1.
  - Denormal inputs are flushed to signed zero.
  - Classify special cases.
- DIVIDE: 26/BITS_PER_CYCLE cycles (default 26). Produces 26 quotient bits (24 significand + guard + round); a nonzero final remainder sets sticky.
- NORMALIZE (1 cycle):
  - Biased exponent = ea - eb + 127.
  - If quotient MSB=0 (ma<mb), shift left 1 and decrement the exponent.
- PACK (1 cycle):
  - Round-to-nearest-even using guard/round/sticky. A mantissa carry-out increments the exponent.
  - Range check: exponent >= 255 gives ±inf with overflow=1 and infinity=1. Exponent <= 0 gives signed zero with underflow=1.
  - Drive quotient and flags, pulse done=1, and deassert busy in the same cycle. Next state IDLE.
- Latency: start accepted at edge T gives done high in cycle T + 3 + 26/BITS_PER_CYCLE (29 by default). Latency is fixed for all inputs, including special cases.
- Special-case results still complete the full latency; the DIVIDE result is discarded:
  - NaN in either operand, 0/0, or inf/inf: 0x7FC00000, NAN=1.
  - Finite nonzero / ±0: signed inf, infinity=1, div_by_zero=1.
  - ±inf / finite: signed inf, infinity=1.
  - Finite / ±inf, or ±0 / finite nonzero: signed zero, all flags 0.
- Result sign is always sa XOR sb, except for NaN (sign 0).
- quotient and flags hold their values after done until the next accepted start clears the flags. quotient itself updates only at PACK.
- start while busy=1 is ignored; no queuing.
- start may be asserted in the cycle done=1; that cycle returns to IDLE, and start is accepted on the following edge when sampled there (back-to-back, one-cycle gap).
- reset=0 overrides start on the same edge.

Optional Feature:
- Macro: FPDIV_INEXACT_EN.
- Defined: adds output port inexact (1 bit). It is valid with done and set when guard, round or sticky is nonzero, or on overflow/underflow. It is cleared on reset and on each accepted start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start at T -> done at T+29, quotient=0x40400000, all flags 0, busy high T+1..T+28.
- a=0x3F800000, b=0x40400000 (1/3) -> quotient=0x3EAAAAAB (RNE), inexact=1 when FPDIV_INEXACT_EN; repeat with BITS_PER_CYCLE=2 -> done at T+16, same result.
- a=0x3F800000/b=0x00000000 -> 0x7F800000, infinity=1, div_by_zero=1; a=0xBF800000/b=0 -> 0xFF800000; a=0/b=0 -> 0x7FC00000, NAN=1.
- a=0x7F000000, b=0x3E800000 -> 0x7F800000, overflow=1, infinity=1; a=0x00800000, b=0x40000000 -> 0x00000000, underflow=1.
- start pulsed again at T+5 while busy -> ignored, single done at T+29; start held through done cycle -> second op accepted, done exactly 30 cycles after first done.
- reset=0 at T+10 mid-DIVIDE -> next cycle busy=0, done=0, quotient=0, flags=0; no done pulse follows.
